// File: rtl/ep_operand_fetch_fwd.sv
// Operand fetch / writeback stage for the even pipe: 128-entry register file
// with stage-7 retirement, per-source forwarding from both pipes and a hazard stall.
module ep_operand_fetch_fwd #(
  parameter int NUM_REGS   = 128,
  parameter int DATA_W     = 128,
  parameter int NUM_STAGES = 7
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                rd_en,
  input  logic [$clog2(NUM_REGS)-1:0]         ra_addr,
  input  logic [$clog2(NUM_REGS)-1:0]         rb_addr,
  input  logic [$clog2(NUM_REGS)-1:0]         rc_addr,
  input  logic [0:DATA_W+$clog2(NUM_REGS)+7]  fw_ep_st_1,
  input  logic [0:DATA_W+$clog2(NUM_REGS)+7]  fw_ep_st_2,
  input  logic [0:DATA_W+$clog2(NUM_REGS)+7]  fw_ep_st_3,
  input  logic [0:DATA_W+$clog2(NUM_REGS)+7]  fw_ep_st_4,
  input  logic [0:DATA_W+$clog2(NUM_REGS)+7]  fw_ep_st_5,
  input  logic [0:DATA_W+$clog2(NUM_REGS)+7]  fw_ep_st_6,
  input  logic [0:DATA_W+$clog2(NUM_REGS)+7]  fw_ep_st_7,
  input  logic [0:DATA_W+$clog2(NUM_REGS)+7]  fw_op_st_1,
  input  logic [0:DATA_W+$clog2(NUM_REGS)+7]  fw_op_st_2,
  input  logic [0:DATA_W+$clog2(NUM_REGS)+7]  fw_op_st_3,
  input  logic [0:DATA_W+$clog2(NUM_REGS)+7]  fw_op_st_4,
  input  logic [0:DATA_W+$clog2(NUM_REGS)+7]  fw_op_st_5,
  input  logic [0:DATA_W+$clog2(NUM_REGS)+7]  fw_op_st_6,
  input  logic [0:DATA_W+$clog2(NUM_REGS)+7]  fw_op_st_7,
  output logic [DATA_W-1:0]                   ra_out,
  output logic [DATA_W-1:0]                   rb_out,
  output logic [DATA_W-1:0]                   rc_out,
  output logic                                operands_valid,
  output logic                                stall
);

  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam int PKT_W  = DATA_W + ADDR_W + 8;
  localparam int RT_LO  = DATA_W;
  localparam int WE_IX  = DATA_W + ADDR_W;
  localparam int RDY_LO = WE_IX + 1;
  localparam int UID_LO = WE_IX + 4;

  // index 0 = even pipe, 1 = odd pipe
  logic [0:PKT_W-1]    w_pkt   [0:1][1:NUM_STAGES];
  logic [DATA_W-1:0]   w_res   [0:1][1:NUM_STAGES];
  logic [ADDR_W-1:0]   w_rt    [0:1][1:NUM_STAGES];
  logic                w_we    [0:1][1:NUM_STAGES];
  logic [2:0]          w_rdy   [0:1][1:NUM_STAGES];
  logic [3:0]          w_unused_uid [0:1][1:NUM_STAGES];

  logic [DATA_W-1:0]   r_regs  [0:NUM_REGS-1];
  logic [ADDR_W-1:0]   w_src_addr [0:2];
  logic [DATA_W-1:0]   w_operand  [0:2];
  logic [2:0]          w_hazard;

  logic [DATA_W-1:0]   r_ra_out;
  logic [DATA_W-1:0]   r_rb_out;
  logic [DATA_W-1:0]   r_rc_out;
  logic                r_valid;

  assign w_pkt[0][1] = fw_ep_st_1;
  assign w_pkt[0][2] = fw_ep_st_2;
  assign w_pkt[0][3] = fw_ep_st_3;
  assign w_pkt[0][4] = fw_ep_st_4;
  assign w_pkt[0][5] = fw_ep_st_5;
  assign w_pkt[0][6] = fw_ep_st_6;
  assign w_pkt[0][7] = fw_ep_st_7;
  assign w_pkt[1][1] = fw_op_st_1;
  assign w_pkt[1][2] = fw_op_st_2;
  assign w_pkt[1][3] = fw_op_st_3;
  assign w_pkt[1][4] = fw_op_st_4;
  assign w_pkt[1][5] = fw_op_st_5;
  assign w_pkt[1][6] = fw_op_st_6;
  assign w_pkt[1][7] = fw_op_st_7;

  genvar gi, gj;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pipe
      for (gj = 1; gj <= NUM_STAGES; gj++) begin : g_stage
        logic [2:0] w_rdy_raw;
        assign w_res[gi][gj]        = w_pkt[gi][gj][0:DATA_W-1];
        assign w_rt[gi][gj]         = w_pkt[gi][gj][RT_LO:RT_LO+ADDR_W-1];
        assign w_we[gi][gj]         = w_pkt[gi][gj][WE_IX];
        assign w_rdy_raw            = w_pkt[gi][gj][RDY_LO:RDY_LO+2];
        assign w_unused_uid[gi][gj] = w_pkt[gi][gj][UID_LO:PKT_W-1];
        // An out-of-range ready stage is treated as "ready only at the last stage".
        assign w_rdy[gi][gj] = (w_rdy_raw == 3'd0) ? 3'd7 : w_rdy_raw;
      end
    end
  endgenerate

  assign w_src_addr[0] = ra_addr;
  assign w_src_addr[1] = rb_addr;
  assign w_src_addr[2] = rc_addr;

  generate
    for (gi = 0; gi < 3; gi++) begin : g_src
      logic              w_hit;
      logic              w_haz;
      logic [DATA_W-1:0] w_fwd;

      // Scan oldest to youngest so the youngest stage (even pipe on a tie) wins.
      always_comb begin
        w_hit = 1'b0;
        w_haz = 1'b0;
        w_fwd = '0;
        for (int s = NUM_STAGES; s >= 1; s--) begin
          for (int p = 1; p >= 0; p--) begin
            if (w_we[p[0]][s[2:0]] && (w_rt[p[0]][s[2:0]] == w_src_addr[gi])) begin
              w_hit = 1'b1;
              w_haz = (s < int'(w_rdy[p[0]][s[2:0]]));
              w_fwd = w_res[p[0]][s[2:0]];
            end
          end
        end
      end

      assign w_operand[gi] = w_hit ? w_fwd : r_regs[w_src_addr[gi]];
      assign w_hazard[gi]  = w_hit & w_haz;
    end
  endgenerate

  assign stall = rd_en & ~reset & (|w_hazard);

  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      always_ff @(posedge clock) begin
        if (reset) begin
          r_regs[gi] <= '0;
        end else if (w_we[0][NUM_STAGES] && (w_rt[0][NUM_STAGES] == ADDR_W'(gi))) begin
          r_regs[gi] <= w_res[0][NUM_STAGES];
        end else if (w_we[1][NUM_STAGES] && (w_rt[1][NUM_STAGES] == ADDR_W'(gi))) begin
          r_regs[gi] <= w_res[1][NUM_STAGES];
        end
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ra_out <= '0;
      r_rb_out <= '0;
      r_rc_out <= '0;
      r_valid  <= 1'b0;
    end else if (rd_en && !stall) begin
      r_ra_out <= w_operand[0];
      r_rb_out <= w_operand[1];
      r_rc_out <= w_operand[2];
      r_valid  <= 1'b1;
    end else begin
      r_valid  <= 1'b0;
    end
  end

  assign ra_out         = r_ra_out;
  assign rb_out         = r_rb_out;
  assign rc_out         = r_rc_out;
  assign operands_valid = r_valid;

endmodule

// File: tb/tb_ep_operand_fetch_fwd.sv
// Bench for ep_operand_fetch_fwd: directed scenarios plus randomized packet
// streams, checked against a behavioural register-file/forwarding model.
module tb_ep_operand_fetch_fwd;

  logic         clock;
  logic         reset;
  logic         rd_en;
  logic [6:0]   ra_addr, rb_addr, rc_addr;
  logic [0:142] fw_ep_st_1, fw_ep_st_2, fw_ep_st_3, fw_ep_st_4, fw_ep_st_5, fw_ep_st_6, fw_ep_st_7;
  logic [0:142] fw_op_st_1, fw_op_st_2, fw_op_st_3, fw_op_st_4, fw_op_st_5, fw_op_st_6, fw_op_st_7;
  logic [127:0] ra_out, rb_out, rc_out;
  logic         operands_valid;
  logic         stall;

  // Model state: packets per pipe (0 even, 1 odd) and stage, register file, outputs
  logic [127:0] m_res [0:1][1:7];
  logic [6:0]   m_rt  [0:1][1:7];
  logic         m_we  [0:1][1:7];
  logic [2:0]   m_r   [0:1][1:7];
  logic [3:0]   m_u   [0:1][1:7];
  logic [127:0] m_regs [0:127];
  logic [127:0] m_ra, m_rb, m_rc;
  logic         m_valid;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  n_txn = 0;
  bit  obs_stall;
  bit  last_stall;

  ep_operand_fetch_fwd dut (
    .clock(clock), .reset(reset), .rd_en(rd_en),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .rc_addr(rc_addr),
    .fw_ep_st_1(fw_ep_st_1), .fw_ep_st_2(fw_ep_st_2), .fw_ep_st_3(fw_ep_st_3),
    .fw_ep_st_4(fw_ep_st_4), .fw_ep_st_5(fw_ep_st_5), .fw_ep_st_6(fw_ep_st_6),
    .fw_ep_st_7(fw_ep_st_7),
    .fw_op_st_1(fw_op_st_1), .fw_op_st_2(fw_op_st_2), .fw_op_st_3(fw_op_st_3),
    .fw_op_st_4(fw_op_st_4), .fw_op_st_5(fw_op_st_5), .fw_op_st_6(fw_op_st_6),
    .fw_op_st_7(fw_op_st_7),
    .ra_out(ra_out), .rb_out(rb_out), .rc_out(rc_out),
    .operands_valid(operands_valid), .stall(stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [0:142] mk(input logic [127:0] res, input logic [6:0] rt,
                                      input logic we, input logic [2:0] r, input logic [3:0] u);
    return {res, rt, we, r, u};
  endfunction

  assign fw_ep_st_1 = mk(m_res[0][1], m_rt[0][1], m_we[0][1], m_r[0][1], m_u[0][1]);
  assign fw_ep_st_2 = mk(m_res[0][2], m_rt[0][2], m_we[0][2], m_r[0][2], m_u[0][2]);
  assign fw_ep_st_3 = mk(m_res[0][3], m_rt[0][3], m_we[0][3], m_r[0][3], m_u[0][3]);
  assign fw_ep_st_4 = mk(m_res[0][4], m_rt[0][4], m_we[0][4], m_r[0][4], m_u[0][4]);
  assign fw_ep_st_5 = mk(m_res[0][5], m_rt[0][5], m_we[0][5], m_r[0][5], m_u[0][5]);
  assign fw_ep_st_6 = mk(m_res[0][6], m_rt[0][6], m_we[0][6], m_r[0][6], m_u[0][6]);
  assign fw_ep_st_7 = mk(m_res[0][7], m_rt[0][7], m_we[0][7], m_r[0][7], m_u[0][7]);
  assign fw_op_st_1 = mk(m_res[1][1], m_rt[1][1], m_we[1][1], m_r[1][1], m_u[1][1]);
  assign fw_op_st_2 = mk(m_res[1][2], m_rt[1][2], m_we[1][2], m_r[1][2], m_u[1][2]);
  assign fw_op_st_3 = mk(m_res[1][3], m_rt[1][3], m_we[1][3], m_r[1][3], m_u[1][3]);
  assign fw_op_st_4 = mk(m_res[1][4], m_rt[1][4], m_we[1][4], m_r[1][4], m_u[1][4]);
  assign fw_op_st_5 = mk(m_res[1][5], m_rt[1][5], m_we[1][5], m_r[1][5], m_u[1][5]);
  assign fw_op_st_6 = mk(m_res[1][6], m_rt[1][6], m_we[1][6], m_r[1][6], m_u[1][6]);
  assign fw_op_st_7 = mk(m_res[1][7], m_rt[1][7], m_we[1][7], m_r[1][7], m_u[1][7]);

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic rand_slot(input int p, input int s, input bit allow_we);
    m_res[p][s] = rnd128();
    m_rt[p][s]  = 7'($urandom_range(0, 15));
    m_we[p][s]  = allow_we && ($urandom_range(0, 2) != 0);
    m_r[p][s]   = 3'($urandom_range(0, 7));
    m_u[p][s]   = 4'($urandom_range(0, 15));
  endtask

  // Junk contents with we=0 everywhere: such packets must be invisible.
  task automatic clear_pkts();
    for (int p = 0; p < 2; p++)
      for (int s = 1; s <= 7; s++)
        rand_slot(p, s, 1'b0);
  endtask

  task automatic shift_pkts(input bit fill);
    for (int p = 0; p < 2; p++) begin
      for (int s = 7; s >= 2; s--) begin
        m_res[p][s] = m_res[p][s-1];
        m_rt[p][s]  = m_rt[p][s-1];
        m_we[p][s]  = m_we[p][s-1];
        m_r[p][s]   = m_r[p][s-1];
        m_u[p][s]   = m_u[p][s-1];
      end
      rand_slot(p, 1, fill);
    end
  endtask

  task automatic set_pkt(input int p, input int s, input logic [127:0] res,
                         input logic [6:0] rt, input logic [2:0] r);
    m_res[p][s] = res;
    m_rt[p][s]  = rt;
    m_we[p][s]  = 1'b1;
    m_r[p][s]   = r;
  endtask

  // Youngest writer of the address wins (even first on a tie); a writer not yet
  // at its ready stage makes the source unavailable.
  task automatic resolve(input logic [6:0] a, output logic [127:0] v, output bit haz);
    bit found;
    int r_eff;
    v = m_regs[a];
    haz = 1'b0;
    found = 1'b0;
    for (int s = 1; s <= 7; s++) begin
      for (int p = 0; p < 2; p++) begin
        if (!found && m_we[p][s] && m_rt[p][s] == a) begin
          found = 1'b1;
          r_eff = (m_r[p][s] == 3'd0) ? 7 : int'(m_r[p][s]);
          if (s >= r_eff) v = m_res[p][s];
          else haz = 1'b1;
        end
      end
    end
  endtask

  task automatic cycle();
    logic [127:0] va, vb, vc;
    bit ha, hb, hc, exp_stall;
    #1;
    resolve(ra_addr, va, ha);
    resolve(rb_addr, vb, hb);
    resolve(rc_addr, vc, hc);
    exp_stall = rd_en && !reset && (ha || hb || hc);
    obs_stall = stall;
    chk("stall", {127'b0, stall}, {127'b0, exp_stall});
    @(posedge clock);
    if (reset) begin
      for (int i = 0; i < 128; i++) m_regs[i] = '0;
      m_ra = '0; m_rb = '0; m_rc = '0; m_valid = 1'b0;
    end else begin
      if (rd_en && !exp_stall) begin
        m_ra = va; m_rb = vb; m_rc = vc; m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      if (m_we[1][7]) m_regs[m_rt[1][7]] = m_res[1][7];
      if (m_we[0][7]) m_regs[m_rt[0][7]] = m_res[0][7];
    end
    last_stall = exp_stall;
    #1;
    chk("ra_out", ra_out, m_ra);
    chk("rb_out", rb_out, m_rb);
    chk("rc_out", rc_out, m_rc);
    chk("valid", {127'b0, operands_valid}, {127'b0, m_valid});
    n_txn++;
    $display("txn %0d rst=%0b rd=%0b ra=%0d rb=%0d rc=%0d stall=%0b valid=%0b ra_out=%h",
             n_txn, reset, rd_en, ra_addr, rb_addr, rc_addr, obs_stall, operands_valid, ra_out);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) m_regs[i] = '0;
    m_ra = '0; m_rb = '0; m_rc = '0; m_valid = 1'b0;
    last_stall = 1'b0;
    reset = 1'b1; rd_en = 1'b0; ra_addr = '0; rb_addr = '0; rc_addr = '0;
    clear_pkts();
    cycle();
    cycle();
    chk("rst_ra", ra_out, 128'd0);
    chk("rst_valid", {127'b0, operands_valid}, 128'd0);

    // Writeback then read
    reset = 1'b0;
    set_pkt(0, 7, 128'd30, 7'd5, 3'd2);
    cycle();
    clear_pkts();
    rd_en = 1'b1; ra_addr = 7'd5;
    cycle();
    chk("wb_ra", ra_out, 128'd30);
    chk("wb_valid", {127'b0, operands_valid}, 128'd1);

    // Forward a ready result
    clear_pkts();
    set_pkt(0, 2, 128'd20, 7'd9, 3'd2);
    rb_addr = 7'd9;
    cycle();
    chk("fwd_rb", rb_out, 128'd20);

    // Hazard until the packet reaches its ready stage
    clear_pkts();
    set_pkt(0, 2, 128'h77, 7'd3, 3'd6);
    rc_addr = 7'd3;
    cycle();
    chk("haz_stall", {127'b0, obs_stall}, 128'd1);
    chk("haz_valid", {127'b0, operands_valid}, 128'd0);
    chk("haz_hold", rc_out, 128'd0);
    for (int k = 0; k < 4; k++) begin
      shift_pkts(1'b0);
      cycle();
    end
    chk("haz_release", {127'b0, obs_stall}, 128'd0);
    chk("haz_rc", rc_out, 128'h77);

    // Youngest stage wins; even pipe wins a tie
    clear_pkts();
    set_pkt(0, 4, 128'd1, 7'd7, 3'd2);
    set_pkt(1, 3, 128'd2, 7'd7, 3'd2);
    ra_addr = 7'd7; rb_addr = 7'd0; rc_addr = 7'd0;
    cycle();
    chk("young_ra", ra_out, 128'd2);
    clear_pkts();
    set_pkt(0, 3, 128'd1, 7'd7, 3'd2);
    set_pkt(1, 3, 128'd2, 7'd7, 3'd2);
    cycle();
    chk("tie_ra", ra_out, 128'd1);

    // Same-address dual write at stage 7
    clear_pkts();
    set_pkt(0, 7, 128'hAA, 7'd12, 3'($urandom_range(0, 7)));
    set_pkt(1, 7, 128'hBB, 7'd12, 3'($urandom_range(0, 7)));
    ra_addr = 7'd12;
    cycle();
    chk("dual_bypass", ra_out, 128'hAA);
    clear_pkts();
    cycle();
    chk("dual_reg", ra_out, 128'hAA);

    // Randomized packet streams; stalled requests are re-presented unchanged
    for (int n = 0; n < 400; n++) begin
      shift_pkts(1'b1);
      if (!last_stall) begin
        rd_en   = ($urandom_range(0, 3) != 0);
        ra_addr = 7'($urandom_range(0, 15));
        rb_addr = 7'($urandom_range(0, 15));
        rc_addr = 7'($urandom_range(0, 15));
      end
      cycle();
    end

    // Reset while a request is stalled
    clear_pkts();
    set_pkt(0, 1, 128'h55, 7'd4, 3'd7);
    rd_en = 1'b1; ra_addr = 7'd4; rb_addr = 7'd1; rc_addr = 7'd2;
    cycle();
    chk("pre_rst_stall", {127'b0, obs_stall}, 128'd1);
    reset = 1'b1;
    cycle();
    chk("mid_rst_stall", {127'b0, obs_stall}, 128'd0);
    chk("mid_rst_ra", ra_out, 128'd0);
    chk("mid_rst_valid", {127'b0, operands_valid}, 128'd0);
    reset = 1'b0;
    clear_pkts();
    for (int i = 0; i < 128; i++) begin
      ra_addr = 7'(i); rb_addr = 7'(i); rc_addr = 7'(127 - i);
      cycle();
      chk("zero_rb", rb_out, 128'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ep_operand_fetch_fwd.md
Name: ep_operand_fetch_fwd

Overview:
- Operand-fetch and writeback stage directly upstream of the even pipe; supplies its ra/rb/rc operand inputs.
- Holds the 128 x 128-bit SPU register file.
- Retires stage-7 packets from the even and odd pipes into the register file.
- Resolves operands by forwarding from the seven per-stage packet buses of both pipes, and raises a stall when a source is still in flight and not yet ready.

Parameters:
- NUM_REGS, 128, number of architectural registers
- DATA_W, 128, register and operand width
- NUM_STAGES, 7, forwarding stages per pipe

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- rd_en  input  1  issue stage presents a valid read request this cycle
- ra_addr  input  7  source-register address for ra
- rb_addr  input  7  source-register address for rb
- rc_addr  input  7  source-register address for rc
- fw_ep_st_1 .. fw_ep_st_7  input  143 each  even-pipe per-stage packets
- fw_op_st_1 .. fw_op_st_7  input  143 each  odd-pipe per-stage packets
- ra_out  output  128  resolved ra operand, registered
- rb_out  output  128  resolved rb operand, registered
- rc_out  output  128  resolved rc operand, registered
- operands_valid  output  1  ra_out/rb_out/rc_out are valid this cycle
- stall  output  1  combinational; the request cannot be satisfied this cycle

Behaviour:
- Packet format, MSB-first index [0:142]:
  - [0:127] result
  - [128:134] rt address
  - [135] write enable (we)
  - [136:138] ready stage R, range 1..7; the result is valid from stage R onward
  - [139:142] unit id, ignored by this block
- Reset:
  - all registers clear to 0
  - ra_out, rb_out, rc_out = 0
  - operands_valid = 0
  - stall = 0 while reset is high
- Writeback, at each posedge when not in reset:
  - if fw_ep_st_7.we = 1: reg[fw_ep_st_7.rt] <= fw_ep_st_7.result
  - if fw_op_st_7.we = 1: reg[fw_op_st_7.rt] <= fw_op_st_7.result
  - if both write the same address, the even pipe wins.
- Per-source resolution (combinational, applied independently to ra, rb and rc):
  - Candidates are packets with we = 1 and rt == source address, across stages 1..7 of both pipes.
  - The youngest matching stage (lowest stage number) is selected. At equal stage, the even pipe wins.
  - If the selected packet's stage s >= R: the operand is that packet's result (forward).
  - If s < R: this source is hazarded.
  - If there is no candidate: the operand is reg[addr].
  - A stage-7 match therefore forwards the value being written this cycle (write-before-read bypass).
- Stall: stall = rd_en & (any of ra/rb/rc hazarded).
- Output registers, at posedge:
  - rd_en = 1 and stall = 0: latch the resolved operands; operands_valid <= 1.
  - rd_en = 1 and stall = 1: ra_out/rb_out/rc_out hold their values; operands_valid <= 0. The issue stage re-presents the same request next cycle.
  - rd_en = 0: outputs hold; operands_valid <= 0.
- Latency: 1 cycle from an unstalled request to operands_valid.
- Reset asserted mid-stall: all outputs clear; the pending request is dropped.
- Packets with we = 0 never match, never write and never stall.
- Packets with R = 0 or R > 7: treated as R = 7.

Test Plan:
- Reset, then write: reset high for 2 cycles, then fw_ep_st_7 = {result=128'd30, rt=5, we=1, R=2}; next cycle rd_en=1, ra_addr=5 -> one cycle later ra_out=30, operands_valid=1, stall never asserted.
- Forward ready: fw_ep_st_2 = {result=128'd20, rt=9, we=1, R=2}; rd_en=1, rb_addr=9, reg[9]=0 -> stall=0; next cycle rb_out=20.
- Hazard stall: fw_ep_st_2 = {rt=3, we=1, R=6}, rc_addr=3, rd_en=1 -> stall=1; outputs hold previous values; operands_valid=0. Once the packet reaches stage 6 -> stall=0; one cycle later rc_out equals the packet result.
- Youngest wins: fw_ep_st_4 = {result=128'd1, rt=7, R=2} and fw_op_st_3 = {result=128'd2, rt=7, R=2}; ra_addr=7 -> ra_out=2. With both packets placed at stage 3 instead -> ra_out=1 (even pipe wins at equal stage).
- Dual write conflict: fw_ep_st_7 = {result=128'hAA, rt=12, we=1} and fw_op_st_7 = {result=128'hBB, rt=12, we=1}; in the same cycle rd_en=1, ra_addr=12 -> ra_out=AA; a later read of reg 12 (no matching packets) returns AA.
- Reset mid-stall: hold a stalling request, assert reset for one cycle -> ra_out/rb_out/rc_out=0, operands_valid=0, stall=0; every register reads back 0 afterwards.
